lcd_rx: RTL and testbench
=========================

LCD_RX -- requirements
Module: lcd_rx

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, 2000, clk cycles busy after a normal instruction or data byte (40 us at 50 MHz; used only with LCD_RX_BUSY_EN).
REQ-002 SHALL have parameter CLEAR_CYCLES, 82000, clk cycles busy after clear display or return home (used only with LCD_RX_BUSY_EN).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  system clock; rst  in  1  asynchronous active-high reset.
REQ-004 lcd_rs, lcd_rw, lcd_e  in  1 each  HD44780 bus control lines from the LCD driver, asynchronous to clk.
REQ-005 lcd_4, lcd_5, lcd_6, lcd_7  in  1 each  HD44780 data nibble D4..D7.
REQ-006 rd_addr  in  7  linear DDRAM read index 0-79; 0-39 is line 1, 40-79 is line 2.
REQ-007 rd_data  out  8  DDRAM byte at rd_addr, registered, 1-cycle latency.
REQ-008 cur_addr  out  7  current DDRAM address in HD44780 encoding (0x00-0x27, 0x40-0x67).
REQ-009 disp_on, cursor_on, blink_on  out  1 each  display-control bits D, C, B.
REQ-010 incr  out  1  entry-mode I/D bit; four_bit  out  1  interface is in 4-bit mode.
REQ-011 busy  out  1  instruction in progress; wr_strobe  out  1  one-cycle pulse per DDRAM write.
REQ-012 ovr  out  1  sticky: strobe dropped while busy; err  out  1  sticky: read strobe or invalid address.

Function
REQ-013 SHALL pass all bus inputs through 2-flop synchronizers and detect the E falling edge on the synchronized lcd_e.
REQ-014 SHALL capture {rs, rw, d7..d4} on the detected falling edge; any strobe with rw=1 SHALL be discarded and SHALL set err.
REQ-015 In 8-bit mode (four_bit=0), each strobe SHALL form byte {d7..d4, 4'h0} and execute immediately.
REQ-016 In 4-bit mode, the first strobe SHALL be the high nibble, the second the low nibble, and the byte SHALL execute after the low nibble.
REQ-017 The rs value of the low-nibble strobe SHALL be used for the byte.
REQ-018 Function set (rs=0, byte[7:5]=001) SHALL set four_bit = ~byte[4] and reset the nibble phase to high.
REQ-019 Clear display (0x01) SHALL write 0x20 to all 80 locations, one per clk, set cur_addr=0x00 and set incr=1.
REQ-020 Return home (0x02-0x03) SHALL set cur_addr=0x00. Entry mode (0x04-0x07) SHALL set incr=byte[1] and ignore the S bit.
REQ-021 Display control (0x08-0x0F) SHALL set disp_on, cursor_on and blink_on from byte[2:0]. Cursor/display shift (0x10-0x1F) and CGRAM address (0x40-0x7F) SHALL be no-ops.
REQ-022 Set DDRAM address (0x80|a) SHALL load cur_addr=a when a is valid; otherwise cur_addr SHALL be unchanged and err SHALL be set.
REQ-023 A data byte (rs=1) SHALL write DDRAM[linear(cur_addr)], pulse wr_strobe and then step cur_addr.
REQ-024 Stepping with incr=1 SHALL follow 0x27->0x40 and 0x67->0x00; with incr=0 it SHALL follow 0x00->0x67 and 0x40->0x27.
REQ-025 The effect of an executed byte SHALL be visible on the outputs no later than 4 clk cycles after the E falling edge reaches the pins.
REQ-026 busy SHALL be high during the clear fill; a strobe detected while busy=1 SHALL be discarded, SHALL set ovr, and SHALL NOT advance the nibble phase.
REQ-027 The state machine SHALL have states IDLE, HI_NIB, LO_NIB, EXEC, FILL and BUSY_WAIT; FILL SHALL return to IDLE, or to BUSY_WAIT when LCD_RX_BUSY_EN is defined.

Reset
REQ-028 rst SHALL force the following, aborting any fill, nibble assembly or busy count: cur_addr=0, disp_on=0, cursor_on=0, blink_on=0, incr=1, four_bit=0, busy=0, wr_strobe=0, ovr=0, err=0, rd_data=0, nibble phase high, state IDLE.
REQ-029 DDRAM contents SHALL NOT be cleared by reset and are undefined until the first clear display.
REQ-030 ovr and err SHALL be cleared only by rst.

Configuration
REQ-031 With macro LCD_RX_BUSY_EN defined, busy SHALL stay high for BUSY_CYCLES after every executed byte, and for CLEAR_CYCLES after clear display or return home (counted from EXEC); strobes in this window SHALL be handled per REQ-026.
REQ-032 Without LCD_RX_BUSY_EN, busy SHALL be high only during the 80-cycle clear fill, and no busy counter SHALL be synthesized.

Verification
REQ-033 After reset, send 8-bit strobes 0x3, 0x3, 0x3, 0x2, then 4-bit byte 0x28 -> four_bit=1, err=0.
REQ-034 In 4-bit mode, send 0x0C, 0x06, then data 0x41 -> disp_on=1, cursor_on=0, incr=1, one wr_strobe pulse, rd_addr=0 reads 0x41, cur_addr=0x01.
REQ-035 Send 0xA7 (address 0x27) and data 0x5A -> rd_addr=39 reads 0x5A, cur_addr=0x40; then send 0xC0 and data 0x42 -> rd_addr=40 reads 0x42.
REQ-036 Send 0x01 without LCD_RX_BUSY_EN -> busy high for 80 cycles, all 80 locations read 0x20, cur_addr=0x00; a strobe issued during the fill -> ovr=1 and the strobe is dropped.
REQ-037 Send strobe with rw=1 -> err=1 and state unchanged; send 0xB0 (invalid address 0x30) -> err=1 and cur_addr unchanged.
REQ-038 Assert rst between the high and low nibble -> four_bit=0; the next strobe is treated as 8-bit per REQ-015.

Source files
------------

// File: rtl/lcd_rx.sv
// HD44780 bus receiver: samples a driver's E/RS/RW/D7..D4 lines and keeps an 80-byte DDRAM mirror.
// Optional macro LCD_RX_BUSY_EN models the controller busy time after each executed byte.
module lcd_rx #(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic       lcd_4,
  input  logic       lcd_5,
  input  logic       lcd_6,
  input  logic       lcd_7,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       incr,
  output logic       four_bit,
  output logic       busy,
  output logic       wr_strobe,
  output logic       ovr,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, HI_NIB, LO_NIB, EXEC, FILL, BUSY_WAIT} state_t;

  state_t     state, nxt;
  logic [1:0] rs_sy, rw_sy, e_sy;
  logic [3:0] d_sy1, d_sy2;
  logic       e_d;
  logic       fall;
  logic       rs_c, rw_c;
  logic [3:0] d_c;

  logic [7:0] byte_r;
  logic       rs_r;
  logic [6:0] fill_cnt;
  logic [7:0] mem [0:79];

  logic       ld_8, ld_hi, ld_lo, set_err, set_ovr, exec, fill_we;
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic       cmd, is_clear, is_home, is_entry, is_disp, is_fset, is_ddram, addr_ok;

  function automatic logic [6:0] lin(input logic [6:0] a);
    return a[6] ? 7'd40 + {1'b0, a[5:0]} : {1'b0, a[5:0]};
  endfunction

  // Line 1 (0x00-0x27) and line 2 (0x40-0x67) form one ring of 80 addresses.
  function automatic logic [6:0] step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_sy <= '0;
      rw_sy <= '0;
      e_sy  <= '0;
      d_sy1 <= '0;
      d_sy2 <= '0;
      e_d   <= 1'b0;
    end else begin
      rs_sy <= {rs_sy[0], lcd_rs};
      rw_sy <= {rw_sy[0], lcd_rw};
      e_sy  <= {e_sy[0], lcd_e};
      d_sy1 <= {lcd_7, lcd_6, lcd_5, lcd_4};
      d_sy2 <= d_sy1;
      e_d   <= e_sy[1];
    end
  end

  assign fall = e_d & ~e_sy[1];
  assign rs_c = rs_sy[1];
  assign rw_c = rw_sy[1];
  assign d_c  = d_sy2;

  assign cmd      = ~rs_r;
  assign is_clear = cmd && (byte_r == 8'h01);
  assign is_home  = cmd && (byte_r[7:1] == 7'b0000001);
  assign is_entry = cmd && (byte_r[7:2] == 6'b000001);
  assign is_disp  = cmd && (byte_r[7:3] == 5'b00001);
  assign is_fset  = cmd && (byte_r[7:5] == 3'b001);
  assign is_ddram = cmd && byte_r[7];
  assign addr_ok  = (byte_r[5:0] <= 6'h27);

`ifdef LCD_RX_BUSY_EN
  localparam int unsigned CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  logic [CNT_W-1:0] bcnt;

  // The count starts at EXEC, so for clear display the fill eats into CLEAR_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
    end else if (exec) begin
      bcnt <= (is_clear || is_home) ? CNT_W'(CLEAR_CYCLES - 1) : CNT_W'(BUSY_CYCLES - 1);
    end else if ((state == FILL || state == BUSY_WAIT) && bcnt != '0) begin
      bcnt <= bcnt - CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // LO_NIB is the only state in which the nibble phase is "low".
  always_comb begin
    nxt     = state;
    ld_8    = 1'b0;
    ld_hi   = 1'b0;
    ld_lo   = 1'b0;
    set_err = 1'b0;
    set_ovr = 1'b0;
    exec    = 1'b0;
    fill_we = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          if (rw_c) begin
            set_err = 1'b1;
          end else if (!four_bit) begin
            ld_8 = 1'b1;
            nxt  = EXEC;
          end else begin
            ld_hi = 1'b1;
            nxt   = HI_NIB;
          end
        end
      end
      HI_NIB: nxt = LO_NIB;
      LO_NIB: begin
        if (fall) begin
          if (rw_c) begin
            set_err = 1'b1;
          end else begin
            ld_lo = 1'b1;
            nxt   = EXEC;
          end
        end
      end
      EXEC: begin
        exec = 1'b1;
        if (is_clear) nxt = FILL;
`ifdef LCD_RX_BUSY_EN
        else          nxt = BUSY_WAIT;
`else
        else          nxt = IDLE;
`endif
      end
      FILL: begin
        fill_we = 1'b1;
        if (fill_cnt == 7'd79) begin
`ifdef LCD_RX_BUSY_EN
          nxt = (bcnt != '0) ? BUSY_WAIT : IDLE;
`else
          nxt = IDLE;
`endif
        end
      end
      BUSY_WAIT: begin
`ifdef LCD_RX_BUSY_EN
        if (bcnt == '0) nxt = IDLE;
`else
        nxt = IDLE;
`endif
      end
      default: nxt = IDLE;
    endcase
    if (fall && (state == FILL || state == BUSY_WAIT)) begin
      set_ovr = 1'b1;
      set_err = rw_c;
    end
  end

  assign busy = (state == FILL) || (state == BUSY_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_r    <= '0;
      rs_r      <= 1'b0;
      cur_addr  <= '0;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      incr      <= 1'b1;
      four_bit  <= 1'b0;
      wr_strobe <= 1'b0;
      ovr       <= 1'b0;
      err       <= 1'b0;
      fill_cnt  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (ld_8) begin
        byte_r <= {d_c, 4'h0};
        rs_r   <= rs_c;
      end
      if (ld_hi) byte_r[7:4] <= d_c;
      if (ld_lo) begin
        byte_r[3:0] <= d_c;
        rs_r        <= rs_c;
      end
      if (set_err) err <= 1'b1;
      if (set_ovr) ovr <= 1'b1;
      if (exec) begin
        if (rs_r) begin
          wr_strobe <= 1'b1;
          cur_addr  <= step(cur_addr, incr);
        end else if (is_ddram) begin
          if (addr_ok) cur_addr <= byte_r[6:0];
          else         err      <= 1'b1;
        end else if (is_fset) begin
          four_bit <= ~byte_r[4];
        end else if (is_disp) begin
          disp_on   <= byte_r[2];
          cursor_on <= byte_r[1];
          blink_on  <= byte_r[0];
        end else if (is_entry) begin
          incr <= byte_r[1];
        end else if (is_home) begin
          cur_addr <= '0;
        end else if (is_clear) begin
          cur_addr <= '0;
          incr     <= 1'b1;
        end
      end
      if (exec && is_clear) fill_cnt <= '0;
      else if (fill_we)     fill_cnt <= fill_cnt + 7'd1;
    end
  end

  assign mem_we    = (exec && rs_r) || fill_we;
  assign mem_waddr = fill_we ? fill_cnt : lin(cur_addr);
  assign mem_wdata = fill_we ? 8'h20 : byte_r;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rd_data <= '0;
    else if (rd_addr < 7'd80) rd_data <= mem[rd_addr];
    else                      rd_data <= '0;
  end

endmodule

// File: tb/tb_lcd_rx.sv
// Scoreboard bench for lcd_rx: stimulus queues expectations, a negedge monitor compares them.
module tb_lcd_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] cur_addr;
  logic       disp_on, cursor_on, blink_on, incr, four_bit, busy, wr_strobe, ovr, err;

  lcd_rx #(.BUSY_CYCLES(2000), .CLEAR_CYCLES(82000)) dut (
    .clk(clk), .rst(rst),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7),
    .rd_addr(rd_addr), .rd_data(rd_data), .cur_addr(cur_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .incr(incr), .four_bit(four_bit), .busy(busy), .wr_strobe(wr_strobe),
    .ovr(ovr), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum {S_CUR, S_FOUR, S_INCR, S_DISP, S_CURS, S_BLINK, S_BUSY,
                S_OVR, S_ERR, S_RD, S_WR, S_RUN, S_WRQ} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t chk_q[$];
  int   wr_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   busy_run = 0;
  int   last_run = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_CUR:   return {25'd0, cur_addr};
      S_FOUR:  return {31'd0, four_bit};
      S_INCR:  return {31'd0, incr};
      S_DISP:  return {31'd0, disp_on};
      S_CURS:  return {31'd0, cursor_on};
      S_BLINK: return {31'd0, blink_on};
      S_BUSY:  return {31'd0, busy};
      S_OVR:   return {31'd0, ovr};
      S_ERR:   return {31'd0, err};
      S_RD:    return {24'd0, rd_data};
      S_WR:    return {31'd0, wr_strobe};
      S_RUN:   return last_run;
      S_WRQ:   return wr_q.size();
      default: return '1;
    endcase
  endfunction

  // Monitor: checks every wr_strobe pulse and drains queued expectations.
  always @(negedge clk) begin
    chk_t        c;
    int          e;
    logic [31:0] act;
    if (wr_strobe) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_pulse: unexpected pulse, cur_addr=%h required no pulse", cur_addr);
      end else begin
        e = wr_q.pop_front();
        if (cur_addr !== e[6:0]) begin
          n_fail++;
          $display("FAIL wr_pulse: cur_addr after write=%h required %h", cur_addr, e[6:0]);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c   = chk_q.pop_front();
      act = observe(c.sel);
      n_cmp++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h required %0h", c.name, act, c.exp);
      end
    end
  end

  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic chk(input string name, input sel_e s, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = s;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // Returns 4 clk edges after E falls, the latest point the effect must be visible.
  task automatic strobe(input logic rs, input logic rw, input logic [3:0] nib);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = rw;
    {lcd_7, lcd_6, lcd_5, lcd_4} = nib;
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic rs, input logic [7:0] b);
    strobe(rs, 1'b0, b[7:4]);
    strobe(rs, 1'b0, b[3:0]);
  endtask

  task automatic rd_chk(input string name, input int a, input logic [7:0] e);
    @(negedge clk);
    rd_addr = a[6:0];
    @(posedge clk);
    #1;
    chk(name, S_RD, {24'd0, e});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_release", S_BUSY, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0;
    {lcd_7, lcd_6, lcd_5, lcd_4} = 4'h0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_cur", S_CUR, 0);     chk("rst_four", S_FOUR, 0);
    chk("rst_incr", S_INCR, 1);   chk("rst_disp", S_DISP, 0);
    chk("rst_curs", S_CURS, 0);   chk("rst_blink", S_BLINK, 0);
    chk("rst_busy", S_BUSY, 0);   chk("rst_ovr", S_OVR, 0);
    chk("rst_err", S_ERR, 0);     chk("rst_rd", S_RD, 0);
    chk("rst_wr", S_WR, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Initialisation into 4-bit mode
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h3);
    chk("init_still8", S_FOUR, 0);
    strobe(1'b0, 1'b0, 4'h2);
    chk("fset_to4", S_FOUR, 1);
    send4(1'b0, 8'h28);
    chk("fset_28_four", S_FOUR, 1);
    chk("fset_28_err", S_ERR, 0);

    send4(1'b0, 8'h0C);
    send4(1'b0, 8'h06);
    wr_q.push_back(7'h01);
    send4(1'b1, 8'h41);
    chk("dc_disp", S_DISP, 1);    chk("dc_curs", S_CURS, 0);
    chk("dc_blink", S_BLINK, 0);  chk("em_incr", S_INCR, 1);
    chk("data_cur", S_CUR, 7'h01);
    rd_chk("rd0_41", 0, 8'h41);

    // Line-wrap stepping
    send4(1'b0, 8'hA7);
    chk("setaddr_27", S_CUR, 7'h27);
    wr_q.push_back(7'h40);
    send4(1'b1, 8'h5A);
    chk("wrap_27_40", S_CUR, 7'h40);
    rd_chk("rd39_5a", 39, 8'h5A);
    send4(1'b0, 8'hC0);
    wr_q.push_back(7'h41);
    send4(1'b1, 8'h42);
    chk("line2_cur", S_CUR, 7'h41);
    rd_chk("rd40_42", 40, 8'h42);

    // Decrement mode
    send4(1'b0, 8'h04);
    chk("em_decr", S_INCR, 0);
    send4(1'b0, 8'h80);
    wr_q.push_back(7'h67);
    send4(1'b1, 8'h33);
    chk("wrap_00_67", S_CUR, 7'h67);
    rd_chk("rd0_33", 0, 8'h33);
    wr_q.push_back(7'h66);
    send4(1'b1, 8'h34);
    rd_chk("rd79_34", 79, 8'h34);
    send4(1'b0, 8'hC0);
    wr_q.push_back(7'h27);
    send4(1'b1, 8'h35);
    chk("wrap_40_27", S_CUR, 7'h27);
    rd_chk("rd40_35", 40, 8'h35);

    send4(1'b0, 8'h0B);
    chk("dc_b_disp", S_DISP, 0);  chk("dc_b_curs", S_CURS, 1);
    chk("dc_b_blink", S_BLINK, 1);
    send4(1'b0, 8'h02);
    chk("home_cur", S_CUR, 0);
    send4(1'b0, 8'h1C);
    send4(1'b0, 8'h40);
    chk("noop_cur", S_CUR, 0);
    chk("noop_disp", S_DISP, 0);

    // Clear display with a strobe landing in the fill
    send4(1'b0, 8'h01);
    chk("clr_busy", S_BUSY, 1);
    chk("clr_cur", S_CUR, 0);
    chk("clr_incr", S_INCR, 1);
    strobe(1'b1, 1'b0, 4'h7);
    chk("fill_ovr", S_OVR, 1);
    chk("fill_busy", S_BUSY, 1);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("fill_len", S_RUN, 80);
    for (int i = 0; i < 80; i++) rd_chk($sformatf("fill_rd%0d", i), i, 8'h20);
    wr_q.push_back(7'h01);
    send4(1'b1, 8'h4B);
    rd_chk("rd0_4b", 0, 8'h4B);
    chk("ovr_sticky", S_OVR, 1);

    // Invalid DDRAM address
    send4(1'b0, 8'hB0);
    chk("bad_addr_err", S_ERR, 1);
    chk("bad_addr_cur", S_CUR, 7'h01);

    // Reset between nibbles
    strobe(1'b0, 1'b0, 4'h2);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_four", S_FOUR, 0); chk("mid_rst_err", S_ERR, 0);
    chk("mid_rst_ovr", S_OVR, 0);   chk("mid_rst_cur", S_CUR, 0);
    wr_q.push_back(7'h01);
    strobe(1'b1, 1'b0, 4'h5);
    chk("post_rst_cur", S_CUR, 7'h01);
    rd_chk("rd0_50", 0, 8'h50);

    // Read strobe
    strobe(1'b0, 1'b1, 4'h3);
    chk("rw_err", S_ERR, 1);
    chk("rw_cur", S_CUR, 7'h01);
    chk("rw_four", S_FOUR, 0);
    wr_q.push_back(7'h02);
    strobe(1'b1, 1'b0, 4'h6);
    chk("post_rw_cur", S_CUR, 7'h02);
    rd_chk("rd1_60", 1, 8'h60);

    repeat (3) @(negedge clk);
    chk("wr_all_seen", S_WRQ, 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
